game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game controller that sequences one play of a song. It drives the shared pause/stop controls of the song player, note-drop display, gameplay comparator and scoring blocks. It runs a start countdown, tracks the consecutive-miss streak from the gameplay hit/miss pulses, and ends the game as cleared (song_done) or failed (miss limit). It replaces direct wiring of SW[1]/SW[0] to those blocks.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown second (benches use small values)
COUNT_SECS, 3, countdown length in seconds; range 0..15
MISS_LIMIT, 8, consecutive misses that end the game as failed; range 1..15

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
start  in  1  level start request (guitar strum/key); acted on at its rising edge only
pause_sw  in  1  level pause request
stop_sw  in  1  level abort request
note_hit  in  1  one-cycle pulse from gameplay
note_miss  in  1  one-cycle pulse from gameplay
song_done  in  1  one-cycle pulse when the song ends
run_pause  out  1  freeze to song/display/gameplay blocks
run_stop  out  1  hold song/display/gameplay blocks stopped
score_clear  out  1  one-cycle pulse to clear the score
state  out  3  current state encoding
countdown  out  4  seconds remaining in the countdown
miss_streak  out  4  current consecutive-miss count
game_over  out  1  high in CLEARED or FAILED
cleared  out  1  high in CLEARED only

Behaviour:
- Reset: state=IDLE, countdown=0, miss_streak=0, score_clear=0, tick counter=0, start_q=1 (so a start held through reset does not fire).
- start_rise = start & ~start_q; start_q <= start every cycle.
- States: IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, CLEARED=4, FAILED=5. Codes 6 and 7 return to IDLE on the next cycle.
- Outputs are Moore-decoded from the state register, so an input change shows on the outputs one cycle later.
  - IDLE: run_stop=1, run_pause=1.
  - COUNTDOWN: run_stop=0, run_pause=1.
  - PLAYING: run_stop=0, run_pause=0.
  - PAUSED, CLEARED, FAILED: run_stop=0, run_pause=1.
- Priority each cycle: reset > stop_sw (in any non-IDLE state, go to IDLE and zero countdown, streak and tick) > per-state rules.
- IDLE: start_rise with stop_sw=0 loads COUNTDOWN. The load sets countdown=COUNT_SECS, tick=0, miss_streak=0 and score_clear=1 for exactly the first cycle spent in COUNTDOWN.
- COUNTDOWN: tick counts 0..TICK_DIV-1 and then wraps. On wrap, countdown decrements. The wrap that takes countdown from 1 to 0 moves to PLAYING. If COUNT_SECS=0, go to PLAYING on the cycle after entry. pause_sw is ignored here.
- PLAYING (checked in this order):
  - song_done goes to CLEARED. It wins over any same-cycle miss.
  - Otherwise note_hit clears miss_streak to 0. A hit wins over a same-cycle note_miss.
  - Otherwise note_miss increments miss_streak. If the new value equals MISS_LIMIT, go to FAILED.
  - Otherwise pause_sw=1 goes to PAUSED.
  - miss_streak saturates at 15.
- PAUSED: note_hit, note_miss and song_done are ignored. pause_sw=0 goes to PLAYING. miss_streak is held.
- CLEARED/FAILED: hit and miss inputs are ignored; miss_streak is held for display. start_rise goes to COUNTDOWN with the IDLE-load actions.
- reset mid-countdown or mid-play: IDLE on the next cycle. score_clear is not pulsed; the scoring block is cleared by stop.

Optional Feature:
RESUME_COUNTDOWN_EN
- Defined: leaving PAUSED goes to COUNTDOWN with countdown=COUNT_SECS and tick=0. It does not pulse score_clear and does not reset miss_streak; the countdown then ends in PLAYING as normal.
- Undefined: PAUSED goes straight to PLAYING when pause_sw falls.

Test Plan:
Bench parameters: TICK_DIV=4, COUNT_SECS=3, MISS_LIMIT=3.
- Start flow: reset, then start rise -> score_clear high 1 cycle; countdown reads 3, 2, 1 at 4-cycle spacing; PLAYING (state=2, run_pause=0) arrives exactly 12 cycles after COUNTDOWN entry.
- Fail: in PLAYING, give misses, then a hit, then misses x3 -> miss_streak goes 1, 2, 0, 1, 2, 3; state=FAILED, game_over=1, cleared=0.
- Simultaneous pulses: note_hit with note_miss in the same cycle -> miss_streak=0. song_done with a miss at streak 2 -> CLEARED, cleared=1.
- Pause: pause_sw=1 in PLAYING, then 5 miss pulses -> streak unchanged, run_pause=1. pause_sw=0 -> PLAYING (macro off), or COUNTDOWN from 3 with no score_clear (macro on).
- Stop and reset: stop_sw=1 in COUNTDOWN at countdown=2 -> IDLE next cycle, run_stop=1, countdown=0. start held high through reset -> stays IDLE until start falls and rises again.
- Restart: in CLEARED, start rise -> COUNTDOWN, score_clear pulse, miss_streak=0.

Source files
------------

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Sequences one play of a song. It runs the start countdown,
//            follows the consecutive-miss streak and ends the game as
//            cleared (song done) or failed (miss limit). It also drives the
//            shared pause/stop controls of the song, display, gameplay and
//            scoring blocks.
// Options  : define RESUME_COUNTDOWN_EN to rerun the countdown when the game
//            leaves PAUSED, instead of resuming play immediately.
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int TICK_DIV   = 50000000,  // clk cycles per countdown second
  parameter int COUNT_SECS = 3,         // countdown length, 0..15
  parameter int MISS_LIMIT = 8          // consecutive misses to fail, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_sw,
  input  logic       stop_sw,
  input  logic       note_hit,
  input  logic       note_miss,
  input  logic       song_done,
  output logic       run_pause,
  output logic       run_stop,
  output logic       score_clear,
  output logic [2:0] state,
  output logic [3:0] countdown,
  output logic [3:0] miss_streak,
  output logic       game_over,
  output logic       cleared
);

  localparam int         TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0] COUNT_INIT = 4'(COUNT_SECS);
  localparam logic [3:0] MISS_LIM   = 4'(MISS_LIMIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAYING   = 3'd2,
    PAUSED    = 3'd3,
    CLEARED   = 3'd4,
    FAILED    = 3'd5
  } state_t;

  state_t        cur_state;
  logic [TW-1:0] tick;
  logic          start_q;
  logic          start_rise;
  logic [3:0]    miss_next;

  // Only a fresh press starts a game; a held button does nothing.
  assign start_rise = start & ~start_q;

  // Saturating increment of the miss streak.
  assign miss_next = (miss_streak == 4'd15) ? 4'd15 : miss_streak + 4'd1;

  // Main sequencer: state, countdown timer, miss streak and score-clear pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= IDLE;
      countdown   <= 4'd0;
      miss_streak <= 4'd0;
      score_clear <= 1'b0;
      tick        <= '0;
      start_q     <= 1'b1;  // a start held through reset must not fire
    end else begin
      start_q     <= start;
      score_clear <= 1'b0;
      if (stop_sw && (cur_state != IDLE)) begin
        cur_state   <= IDLE;
        countdown   <= 4'd0;
        miss_streak <= 4'd0;
        tick        <= '0;
      end else begin
        case (cur_state)
          IDLE: begin
            if (start_rise && !stop_sw) begin
              cur_state   <= COUNTDOWN;
              countdown   <= COUNT_INIT;
              tick        <= '0;
              miss_streak <= 4'd0;
              score_clear <= 1'b1;
            end
          end
          COUNTDOWN: begin
            if (COUNT_SECS == 0) begin
              cur_state <= PLAYING;
            end else if (tick == TICK_LAST) begin
              tick      <= '0;
              countdown <= countdown - 4'd1;
              if (countdown == 4'd1) begin
                cur_state <= PLAYING;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end
          PLAYING: begin
            if (song_done) begin
              cur_state <= CLEARED;
            end else if (note_hit) begin
              miss_streak <= 4'd0;
            end else if (note_miss) begin
              miss_streak <= miss_next;
              if (miss_next == MISS_LIM) begin
                cur_state <= FAILED;
              end
            end else if (pause_sw) begin
              cur_state <= PAUSED;
            end
          end
          PAUSED: begin
            if (!pause_sw) begin
`ifdef RESUME_COUNTDOWN_EN
              cur_state <= COUNTDOWN;
              countdown <= COUNT_INIT;
              tick      <= '0;
`else
              cur_state <= PLAYING;
`endif
            end
          end
          CLEARED, FAILED: begin
            if (start_rise) begin
              cur_state   <= COUNTDOWN;
              countdown   <= COUNT_INIT;
              tick        <= '0;
              miss_streak <= 4'd0;
              score_clear <= 1'b1;
            end
          end
          default: begin
            // Unused encodings fall back to a safe idle state.
            cur_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Moore decode of the state register; unused codes look like IDLE.
  assign state     = cur_state;
  assign run_stop  = (cur_state == IDLE) || (state > 3'd5);
  assign run_pause = (cur_state != PLAYING);
  assign game_over = (cur_state == CLEARED) || (cur_state == FAILED);
  assign cleared   = (cur_state == CLEARED);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Directed self-checking bench for game_sequencer
//            (TICK_DIV=4, COUNT_SECS=3, MISS_LIMIT=3). Honours
//            RESUME_COUNTDOWN_EN for the pause-exit expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause_sw, stop_sw, note_hit, note_miss, song_done;
  logic       run_pause, run_stop, score_clear, game_over, cleared;
  logic [2:0] state;
  logic [3:0] countdown, miss_streak;

  int vectors = 0;
  int miscompares = 0;

  game_sequencer #(.TICK_DIV(4), .COUNT_SECS(3), .MISS_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pause_sw(pause_sw),
    .stop_sw(stop_sw), .note_hit(note_hit), .note_miss(note_miss),
    .song_done(song_done), .run_pause(run_pause), .run_stop(run_stop),
    .score_clear(score_clear), .state(state), .countdown(countdown),
    .miss_streak(miss_streak), .game_over(game_over), .cleared(cleared)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic miss_pulse();
    note_miss = 1'b1; step(); note_miss = 1'b0;
  endtask

  task automatic hit_pulse();
    note_hit = 1'b1; step(); note_hit = 1'b0;
  endtask

  // Start rise from IDLE/CLEARED/FAILED; leaves the DUT in its first COUNTDOWN cycle.
  task automatic start_game();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; pause_sw = 0; stop_sw = 0;
    note_hit = 0; note_miss = 0; song_done = 0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_countdown", countdown, 0);
    check("rst_streak", miss_streak, 0);
    check("rst_score_clear", score_clear, 0);
    check("rst_run_stop", run_stop, 1);
    check("rst_run_pause", run_pause, 1);
    reset = 1'b0; step();

    // Start flow: countdown 3,2,1 at 4-cycle spacing, PLAYING 12 cycles after entry
    start_game();
    check("cd_entry_state", state, 1);
    check("cd_entry_clear", score_clear, 1);
    check("cd_entry_count", countdown, 3);
    check("cd_entry_run_stop", run_stop, 0);
    check("cd_entry_run_pause", run_pause, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) check("cd_clear_drop", score_clear, 0);
      if (i < 12) begin
        check("cd_state", state, 1);
        check("cd_count", countdown, (i < 4) ? 3 : (i < 8) ? 2 : 1);
      end
    end
    check("play_state", state, 2);
    check("play_run_pause", run_pause, 0);
    check("play_count", countdown, 0);

    // Fail: miss, miss, hit, miss x3
    miss_pulse(); check("streak_1", miss_streak, 1);
    miss_pulse(); check("streak_2", miss_streak, 2);
    hit_pulse();  check("streak_hit", miss_streak, 0);
    miss_pulse(); check("streak_1b", miss_streak, 1);
    miss_pulse(); check("streak_2b", miss_streak, 2);
    check("not_failed_yet", state, 2);
    miss_pulse(); check("streak_3", miss_streak, 3);
    check("failed_state", state, 5);
    check("failed_game_over", game_over, 1);
    check("failed_cleared", cleared, 0);
    miss_pulse(); check("failed_hold_streak", miss_streak, 3);

    // Restart from FAILED
    start_game();
    check("rf_state", state, 1);
    check("rf_clear", score_clear, 1);
    check("rf_streak", miss_streak, 0);
    repeat (12) step();
    check("rf_play", state, 2);

    // Simultaneous pulses
    miss_pulse(); check("sim_streak_1", miss_streak, 1);
    note_hit = 1'b1; note_miss = 1'b1; step(); note_hit = 1'b0; note_miss = 1'b0;
    check("hit_beats_miss", miss_streak, 0);
    miss_pulse(); miss_pulse();
    check("sim_streak_2", miss_streak, 2);
    song_done = 1'b1; note_miss = 1'b1; step(); song_done = 1'b0; note_miss = 1'b0;
    check("done_state", state, 4);
    check("done_cleared", cleared, 1);
    check("done_game_over", game_over, 1);
    check("done_streak", miss_streak, 2);
    check("done_run_pause", run_pause, 1);

    // Restart from CLEARED
    start_game();
    check("rc_state", state, 1);
    check("rc_clear", score_clear, 1);
    check("rc_streak", miss_streak, 0);
    repeat (12) step();
    check("rc_play", state, 2);

    // Pause: misses and song_done are ignored while paused
    miss_pulse(); check("pre_pause_streak", miss_streak, 1);
    pause_sw = 1'b1; step();
    check("paused_state", state, 3);
    check("paused_run_pause", run_pause, 1);
    repeat (5) miss_pulse();
    song_done = 1'b1; step(); song_done = 1'b0;
    check("paused_streak", miss_streak, 1);
    check("paused_hold", state, 3);
    pause_sw = 1'b0; step();
`ifdef RESUME_COUNTDOWN_EN
    check("resume_state", state, 1);
    check("resume_count", countdown, 3);
    check("resume_no_clear", score_clear, 0);
    check("resume_streak", miss_streak, 1);
    repeat (12) step();
    check("resume_play", state, 2);
`else
    check("resume_state", state, 2);
    check("resume_run_pause", run_pause, 0);
    check("resume_streak", miss_streak, 1);
`endif

    // Stop in PLAYING, then in COUNTDOWN at countdown=2
    stop_sw = 1'b1; step(); stop_sw = 1'b0;
    check("stop_play_state", state, 0);
    check("stop_play_streak", miss_streak, 0);
    start_game();
    repeat (4) step();
    check("stop_cd_pre", countdown, 2);
    stop_sw = 1'b1; step();
    check("stop_cd_state", state, 0);
    check("stop_cd_run_stop", run_stop, 1);
    check("stop_cd_count", countdown, 0);
    start = 1'b1; step(); start = 1'b0;
    check("stop_blocks_start", state, 0);
    stop_sw = 1'b0; step();

    // Reset mid-countdown with start held through reset
    start_game();
    step();
    start = 1'b1; reset = 1'b1; step();
    check("rst_mid_state", state, 0);
    check("rst_mid_clear", score_clear, 0);
    step(); reset = 1'b0; step(); step();
    check("held_start_idle", state, 0);
    start = 1'b0; step();
    check("held_release_idle", state, 0);
    start = 1'b1; step(); start = 1'b0;
    check("fresh_start", state, 1);
    check("fresh_start_clear", score_clear, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
